seg_display_arbiter: RTL
========================

# seg_display_arbiter

Shares the Basys 3 four-digit seven-segment display between two requesters, each presenting a 4-digit BCD value, and sequences the anode scan itself. It sits between the counter/status logic and the board cathode/anode pins. It grants display ownership only at frame boundaries, enforces a minimum hold time, and inserts an anti-ghosting blank interval between digits. It latches each frame's value so the display never tears.

## Interface
- DWELL_CYCLES, 400000, cycles a digit is driven (4 ms at 100 MHz)
- BLANK_CYCLES, 4000, cycles all anodes are off before each digit
- HOLD_FRAMES, 63, minimum completed frames an owner keeps the grant against a competing request
- intClk  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-high reset
- req  in  2  req[i] high = requester i wants the display (level)
- bcd0  in  16  requester 0 digits, [15:12]=AN3 … [3:0]=AN0
- bcd1  in  16  requester 1 digits, same layout
- grant  out  2  one-hot current owner; 2'b00 = idle
- sevenSeg  out  7  cathodes, active low, MSB=A … LSB=G
- anodes  out  4  active low, anodes[k]=ANk
- frame_tick  out  1  one-cycle pulse on the last cycle of each frame

## Operation
- Scan FSM: BLANK(k) → DRIVE(k) for k=0,1,2,3, then back to BLANK(0); BLANK lasts BLANK_CYCLES, DRIVE lasts DWELL_CYCLES. It runs continuously, including while idle.
- In BLANK: anodes=4'b1111, sevenSeg=7'b1111111. In DRIVE(k): exactly anodes[k]=0.
- Frame latch: a 16-bit register loads on the frame-end edge from the newly granted requester's bcd. It loads 0 when idle. While idle, DRIVE keeps anodes=4'b1111.
- Decode per nibble: 0–9 map to the standard patterns (0=7'b0000001, 8=7'b0000000). Nibbles 10–15 map to a dash, 7'b1111110.
- Arbiter states are IDLE, OWN0 and OWN1. Next owner is evaluated only at frame end (frame_tick=1):
  - IDLE: one requester → grant it. Both → grant the one opposite the round-robin pointer's last owner. After reset the pointer favours 0.
  - OWNi, req[i] dropped → switch to the other requester if it is requesting, else go to IDLE.
  - OWNi, req[i] held, other requesting, hold count ≥ HOLD_FRAMES → switch to the other requester.
  - OWNi otherwise → stay.
- Hold counter counts frames completed under the current owner. It saturates at HOLD_FRAMES and clears on every ownership change, including entry to IDLE.
- Requests changing mid-frame have no effect until frame end. The frame in progress always completes with its latched data.

## Timing
- Frame length is 4×(BLANK_CYCLES+DWELL_CYCLES) cycles; defaults give 1,616,000 cycles (16.16 ms).
- frame_tick is high during the last DRIVE(3) cycle. On that clock edge, grant, the frame latch, the pointer and the hold counter update together, and the scan enters BLANK(0).
- Request-to-grant latency is at most one frame plus one cycle from IDLE.
- All outputs are registered; no combinational path from req or bcd to any output.
- Reset values: grant=2'b00, anodes=4'b1111, sevenSeg=7'b1111111, frame_tick=0. After reset the scan is in BLANK(0) with counters at 0, hold=0, pointer favouring 0.
- Reset asserted mid-frame forces all reset values immediately (asynchronous). The first frame_tick comes exactly one full frame after release.
- Counter widths are $clog2 of the respective maximum; the hold counter is $clog2(HOLD_FRAMES+1).

## Configuration
- SEG_LEADING_ZERO_BLANK_EN defined: in DRIVE(k) for k=3..1, the digit is blanked (sevenSeg=7'b1111111, anode still asserted) when that nibble and all higher nibbles of the latched value are 0. AN0 is never blanked.
- Not defined: all four digits are always displayed.

## Structure
- Shared package seg_pkg holds:
  - the ten digit patterns, the dash and blank constants;
  - the arbiter-state enum and the scan-phase enum;
  - a bcd_to_seg function.
- One sub-module, seg_decoder: a 4-bit nibble plus blank flag in, 7-bit cathodes out. The arbiter, scan FSM and frame latch live in the top module.

## Test plan
All tests use DWELL_CYCLES=10, BLANK_CYCLES=2, HOLD_FRAMES=2; frame = 48 cycles.
- Release reset with req=00 → grant=00 and anodes=1111 for 3 frames; frame_tick every 48 cycles, first at cycle 48.
- req=01, bcd0=16'h1234 → grant=01 after the first frame_tick. Next frame shows: AN0=four (1001100), AN1=three, AN2=two, AN3=one (1001111); 2 blank cycles precede each digit.
- Both requesting from IDLE → grant=01. req1 held → after 2 owned frames, grant=10 at the frame end; with both still held, back to 01 two frames later.
- Change bcd0 mid-frame from 16'h1111 to 16'h2222 → current frame shows all ones; next frame shows all twos.
- bcd0=16'h00A5 → AN1 shows dash 1111110. With SEG_LEADING_ZERO_BLANK_EN, bcd0=16'h0007 → AN3..AN1 cathodes 1111111, AN0=seven.
- Assert reset in DRIVE(2) while grant=10 → same cycle: grant=00, anodes=1111, sevenSeg=1111111.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants, state enums and the BCD-to-cathode mapping for the
// seven-segment display arbiter. Cathode patterns are active low, MSB=A .. LSB=G.
package seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_DASH  = 7'b1111110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_OWN0 = 2'd1,
      ARB_OWN1 = 2'd2
   } arb_state_t;

   typedef enum logic {
      PH_BLANK = 1'b0,
      PH_DRIVE = 1'b1
   } scan_phase_t;

   // Non-decimal nibbles show a dash so corrupted BCD is visible on the board.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
      case (nibble)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_DASH;
      endcase
   endfunction

endpackage

// File: rtl/seg_display_arbiter_decoder.sv
// Nibble-to-cathode decoder with a forced-blank override.
module seg_decoder
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = blank ? SEG_BLANK : bcd_to_seg(nibble);
   end

endmodule

// File: rtl/seg_display_arbiter.sv
// Two-requester arbiter for the Basys 3 four-digit display with its own anode scan.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks leading zeros on AN3..AN1.
module seg_display_arbiter
   import seg_pkg::*;
#(
   parameter int DWELL_CYCLES = 400000,
   parameter int BLANK_CYCLES = 4000,
   parameter int HOLD_FRAMES  = 63
) (
   input  logic        intClk,
   input  logic        reset,
   input  logic [1:0]  req,
   input  logic [15:0] bcd0,
   input  logic [15:0] bcd1,
   output logic [1:0]  grant,
   output logic [6:0]  sevenSeg,
   output logic [3:0]  anodes,
   output logic        frame_tick
);

   localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int HW      = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_FRAMES);

   scan_phase_t phase_q, phase_d;
   logic [1:0]     digit_q, digit_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           frame_end;

   arb_state_t     arb_q, arb_d;
   logic [HW-1:0]  hold_q, hold_d, hold_inc;
   logic           last_q, last_d;
   logic [15:0]    frame_q, frame_d;
   logic [1:0]     grant_d;

   logic [3:0]     anodes_d;
   logic           tick_d;
   logic [3:0]     nib_sel;
   logic           blank_sel;
   logic           lead_zero;
   logic [6:0]     seg_d;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      phase_d   = phase_q;
      digit_d   = digit_q;
      cnt_d     = cnt_q + CW'(1);
      frame_end = (phase_q == PH_DRIVE) && (digit_q == 2'd3) && (cnt_q == DWELL_LAST);
      case (phase_q)
         PH_BLANK: if (cnt_q == BLANK_LAST) begin
            phase_d = PH_DRIVE;
            cnt_d   = '0;
         end
         PH_DRIVE: if (cnt_q == DWELL_LAST) begin
            phase_d = PH_BLANK;
            digit_d = digit_q + 2'd1;
            cnt_d   = '0;
         end
         default: begin
            phase_d = PH_BLANK;
            cnt_d   = '0;
         end
      endcase
   end

   // Ownership, hold count, pointer and frame latch only move on the frame-end edge.
   always_comb begin
      arb_d    = arb_q;
      hold_d   = hold_q;
      last_d   = last_q;
      frame_d  = frame_q;
      hold_inc = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
      if (frame_end) begin
         case (arb_q)
            ARB_IDLE: begin
               case (req)
                  2'b01:   arb_d = ARB_OWN0;
                  2'b10:   arb_d = ARB_OWN1;
                  2'b11:   arb_d = last_q ? ARB_OWN0 : ARB_OWN1;
                  default: arb_d = ARB_IDLE;
               endcase
            end
            ARB_OWN0: begin
               if (!req[0])                            arb_d = req[1] ? ARB_OWN1 : ARB_IDLE;
               else if (req[1] && hold_inc >= HOLD_MAX) arb_d = ARB_OWN1;
            end
            ARB_OWN1: begin
               if (!req[1])                            arb_d = req[0] ? ARB_OWN0 : ARB_IDLE;
               else if (req[0] && hold_inc >= HOLD_MAX) arb_d = ARB_OWN0;
            end
            default: arb_d = ARB_IDLE;
         endcase

         if (arb_d != arb_q)         hold_d = '0;
         else if (arb_q != ARB_IDLE) hold_d = hold_inc;

         case (arb_d)
            ARB_OWN0: begin
               frame_d = bcd0;
               last_d  = 1'b0;
            end
            ARB_OWN1: begin
               frame_d = bcd1;
               last_d  = 1'b1;
            end
            default: frame_d = '0;
         endcase
      end
      grant_d = {arb_d == ARB_OWN1, arb_d == ARB_OWN0};
   end

   always_comb begin
      lead_zero = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
      case (digit_d)
         2'd3:    lead_zero = (frame_q[15:12] == 4'd0);
         2'd2:    lead_zero = (frame_q[15:8]  == 8'd0);
         2'd1:    lead_zero = (frame_q[15:4]  == 12'd0);
         default: lead_zero = 1'b0;
      endcase
`endif
   end

   // Outputs are decoded from the next scan state so the registered pins line up with it.
   always_comb begin
      nib_sel   = frame_q[{digit_d, 2'b00} +: 4];
      blank_sel = (phase_d == PH_BLANK) || (arb_q == ARB_IDLE) || lead_zero;
      anodes_d  = ((phase_d == PH_DRIVE) && (arb_q != ARB_IDLE)) ? ~(4'b0001 << digit_d) : 4'b1111;
      tick_d    = (phase_d == PH_DRIVE) && (digit_d == 2'd3) && (cnt_d == DWELL_LAST);
   end

   seg_decoder u_dec (
      .nibble (nib_sel),
      .blank  (blank_sel),
      .seg    (seg_d)
   );

   // NOTE: sequential state uses non-blocking assignments so all flops sample together.
   always_ff @(posedge intClk or posedge reset) begin
      if (reset) begin
         phase_q    <= PH_BLANK;
         digit_q    <= 2'd0;
         cnt_q      <= '0;
         arb_q      <= ARB_IDLE;
         hold_q     <= '0;
         last_q     <= 1'b1;
         frame_q    <= '0;
         grant      <= 2'b00;
         anodes     <= 4'b1111;
         sevenSeg   <= SEG_BLANK;
         frame_tick <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         digit_q    <= digit_d;
         cnt_q      <= cnt_d;
         arb_q      <= arb_d;
         hold_q     <= hold_d;
         last_q     <= last_d;
         frame_q    <= frame_d;
         grant      <= grant_d;
         anodes     <= anodes_d;
         sevenSeg   <= seg_d;
         frame_tick <= tick_d;
      end
   end

endmodule
